// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: serves one I-cache or D-cache block fill at a time from a
// shared pipelined memory. D-side misses have priority. Write-through stores
// pass straight to memory in IDLE cycles that have no miss. The pipeline stall
// is generated combinationally so the CPU freezes in the cycle the miss appears.
//
// Optional feature macro: CACHE_FILL_CWF_EN (critical-word-first fill order).
// When this macro is undefined, every fill starts at word 0 of the block.

module cache_fill_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        fill_sel,
    output logic        fill_we,
    output logic [2:0]  fill_word_idx,
    output logic [15:0] fill_data,
    output logic        fill_tag_we
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

    // Reject configurations the address arithmetic cannot represent.
    generate
        if ((WORDS_PER_BLOCK != (1 << IDX_W)) || (IDX_W < 1) || (MEM_LATENCY < 1)) begin : g_bad_cfg
            $error("cache_fill_arbiter: WORDS_PER_BLOCK must be a power of two >= 2 and MEM_LATENCY >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [14-IDX_W:0]   base_reg;      // block-aligned part of the miss address
    logic [IDX_W-1:0]    ic_reg;        // word index of the next read to issue
    logic [IDX_W-1:0]    rc_reg;        // word index of the next beat to return
    logic [IDX_W-1:0]    start_reg;     // first word of this fill; both counters wrap back to it
    logic                issuing_reg;   // reads still outstanding to be issued
    logic                fill_sel_reg;

    logic                miss_any;
    logic [15:0]         miss_addr;
    logic [IDX_W-1:0]    start_next;
    logic [IDX_W-1:0]    ic_next;
    logic [IDX_W-1:0]    rc_next;
    logic                wr_go;
    logic                rd_go;
    logic                unused_addr_bits;

    // Miss selection with D-side priority, and the starting word for a new fill.
    always_comb begin
        miss_any  = i_miss | d_miss;
        miss_addr = d_miss ? d_miss_addr : i_miss_addr;
`ifdef CACHE_FILL_CWF_EN
        start_next = miss_addr[IDX_W:1];
`else
        start_next = '0;
`endif
        ic_next = ic_reg + 1'b1;
        rc_next = rc_reg + 1'b1;
    end

    // Byte-offset bits below the block base only matter for critical-word-first.
    assign unused_addr_bits = ^miss_addr[IDX_W:0];

    // Fill sequencer: latch the miss, issue one read per cycle, count the
    // returning beats, then spend one cycle writing the tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            ic_reg       <= '0;
            rc_reg       <= '0;
            start_reg    <= '0;
            issuing_reg  <= 1'b0;
            fill_sel_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss_any) begin
                        state_reg    <= FILL;
                        base_reg     <= miss_addr[15:IDX_W+1];
                        fill_sel_reg <= d_miss;
                        ic_reg       <= start_next;
                        rc_reg       <= start_next;
                        start_reg    <= start_next;
                        issuing_reg  <= 1'b1;
                    end
                end
                FILL: begin
                    if (issuing_reg) begin
                        ic_reg <= ic_next;
                        if (ic_next == start_reg) begin
                            issuing_reg <= 1'b0;
                        end
                    end
                    if (mem_valid) begin
                        rc_reg <= rc_next;
                        if (rc_next == start_reg) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Memory request mux: fill reads in FILL, write-through stores only in a
    // miss-free IDLE cycle. Unused fields are held at zero.
    always_comb begin
        wr_go     = (state_reg == IDLE) && !miss_any && d_wr;
        rd_go     = (state_reg == FILL) && issuing_reg;
        mem_en    = wr_go | rd_go;
        mem_wr    = wr_go;
        mem_wdata = wr_go ? d_wr_data : 16'h0000;
        if (wr_go) begin
            mem_addr = d_wr_addr;
        end else if (rd_go) begin
            mem_addr = {base_reg, ic_reg, 1'b0};
        end else begin
            mem_addr = 16'h0000;
        end
    end

    // Cache-side outputs: beats are forwarded in the cycle they arrive, and
    // beats outside FILL (including those in flight across a reset) are dropped.
    always_comb begin
        stall         = (state_reg != IDLE) | miss_any;
        fill_we       = (state_reg == FILL) && mem_valid;
        fill_data     = fill_we ? mem_rdata : 16'h0000;
        fill_word_idx = fill_we ? 3'(rc_reg) : 3'd0;
        fill_tag_we   = (state_reg == DONE);
        fill_sel      = fill_sel_reg;
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed testbench for cache_fill_arbiter with a fixed-latency pipelined
// memory model. Expected per-cycle outputs are derived from the fill timeline
// relative to the cycle in which the miss is presented.

module tb_cache_fill_arbiter;

    localparam int L   = 4;
    localparam int WPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0;
    logic [15:0] i_miss_addr = 16'h0;
    logic        d_miss = 1'b0;
    logic [15:0] d_miss_addr = 16'h0;
    logic        d_wr = 1'b0;
    logic [15:0] d_wr_addr = 16'h0;
    logic [15:0] d_wr_data = 16'h0;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        fill_sel;
    logic        fill_we;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;
    logic        fill_tag_we;

    int errors = 0;
    int checks = 0;

    cache_fill_arbiter #(.WORDS_PER_BLOCK(WPB), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .stall(stall), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fill_sel(fill_sel), .fill_we(fill_we),
        .fill_word_idx(fill_word_idx), .fill_data(fill_data),
        .fill_tag_we(fill_tag_we)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Memory model: a read seen in cycle c returns its beat in cycle c+L.
    bit          cap_v;
    logic [15:0] cap_a = 16'h0;
    bit          pipe_v [1:L];
    logic [15:0] pipe_a [1:L];

    always @(negedge clk) begin
        cap_v = mem_en && !mem_wr;
        cap_a = mem_addr;
    end

    always @(posedge clk) begin
        #1;
        for (int k = L; k >= 2; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_a[k] = pipe_a[k-1];
        end
        pipe_v[1] = cap_v;
        pipe_a[1] = cap_a;
        mem_valid = pipe_v[L];
        mem_rdata = pipe_v[L] ? mdata(pipe_a[L]) : 16'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Checks one miss-to-DONE timeline; rel 0 is the cycle the miss is presented.
    task automatic run_fill(input string nm, input logic [15:0] maddr, input logic sel,
                            input int last_rel, input bit drop);
        logic [2:0]  st;
        logic [2:0]  wi;
        logic [15:0] a;
        bit          e_en;
        bit          e_we;
`ifdef CACHE_FILL_CWF_EN
        st = maddr[3:1];
`else
        st = 3'd0;
`endif
        for (int rel = 0; rel <= last_rel; rel++) begin
            @(negedge clk);
            e_en = (rel >= 1) && (rel <= WPB);
            e_we = (rel >= 1 + L) && (rel <= WPB + L);
            check($sformatf("%s r%0d stall", nm, rel), 32'(stall), 32'(rel <= WPB + 1 + L));
            check($sformatf("%s r%0d mem_en", nm, rel), 32'(mem_en), 32'(e_en));
            check($sformatf("%s r%0d mem_wr", nm, rel), 32'(mem_wr), 32'd0);
            if (e_en) begin
                wi = st + 3'(rel - 1);
                a  = {maddr[15:4], wi, 1'b0};
                check($sformatf("%s r%0d mem_addr", nm, rel), 32'(mem_addr), 32'(a));
            end
            check($sformatf("%s r%0d fill_we", nm, rel), 32'(fill_we), 32'(e_we));
            if (e_we) begin
                wi = st + 3'(rel - 1 - L);
                a  = {maddr[15:4], wi, 1'b0};
                check($sformatf("%s r%0d idx", nm, rel), 32'(fill_word_idx), 32'(wi));
                check($sformatf("%s r%0d data", nm, rel), 32'(fill_data), 32'(mdata(a)));
            end
            check($sformatf("%s r%0d tag_we", nm, rel), 32'(fill_tag_we), 32'(rel == WPB + 1 + L));
            if (rel >= 1) begin
                check($sformatf("%s r%0d fill_sel", nm, rel), 32'(fill_sel), 32'(sel));
            end
            @(posedge clk);
            #1;
            if (rel == WPB + 1 + L && drop) begin
                if (sel) d_miss = 1'b0;
                else     i_miss = 1'b0;
            end
        end
        $display("fill %s addr=%04h sel=%0d cycles=%0d errors=%0d", nm, maddr, sel, last_rel + 1, errors);
    endtask

    task automatic check_idle(input string nm);
        @(negedge clk);
        check({nm, " stall"}, 32'(stall), 32'd0);
        check({nm, " mem_en"}, 32'(mem_en), 32'd0);
        check({nm, " fill_we"}, 32'(fill_we), 32'd0);
        check({nm, " tag_we"}, 32'(fill_tag_we), 32'd0);
        check({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({nm, " idx"}, 32'(fill_word_idx), 32'd0);
        check({nm, " data"}, 32'(fill_data), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string nm, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        check({nm, " mem_en"}, 32'(mem_en), 32'd1);
        check({nm, " mem_wr"}, 32'(mem_wr), 32'd1);
        check({nm, " mem_addr"}, 32'(mem_addr), 32'(a));
        check({nm, " mem_wdata"}, 32'(mem_wdata), 32'(d));
        check({nm, " stall"}, 32'(stall), 32'd0);
        $display("store %s addr=%04h data=%04h errors=%0d", nm, a, d, errors);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values, and stall following the miss inputs during reset.
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        i_miss = 1'b1;
        @(negedge clk);
        check("reset stall=miss", 32'(stall), 32'd1);
        check("reset no req", 32'(mem_en), 32'd0);
        check("reset fill_sel", 32'(fill_sel), 32'd0);
        @(posedge clk);
        #1;
        i_miss = 1'b0;
        rst = 1'b0;
        check_idle("post-reset");

        // I-miss at 0x0036.
        i_miss = 1'b1;
        i_miss_addr = 16'h0036;
        run_fill("imiss", 16'h0036, 1'b0, WPB + 1 + L, 1'b1);
        check_idle("after imiss");

        // Simultaneous misses: D first, then I, stall never drops.
        d_miss = 1'b1;
        d_miss_addr = 16'h1000;
        i_miss = 1'b1;
        i_miss_addr = 16'h0200;
        run_fill("both-d", 16'h1000, 1'b1, WPB + 1 + L, 1'b1);
        run_fill("both-i", 16'h0200, 1'b0, WPB + 1 + L, 1'b1);
        check_idle("after both");

        // Write-through store in IDLE.
        d_wr = 1'b1;
        d_wr_addr = 16'h2002;
        d_wr_data = 16'hBEEF;
        check_write("wt", 16'h2002, 16'hBEEF);
        d_wr = 1'b0;
        check_idle("after wt");

        // Store colliding with a D-miss: held off until the fill completes.
        d_wr = 1'b1;
        d_wr_addr = 16'h2004;
        d_wr_data = 16'h1234;
        d_miss = 1'b1;
        d_miss_addr = 16'h040A;
        run_fill("wr+dmiss", 16'h040A, 1'b1, WPB + 1 + L, 1'b1);
        check_write("held", 16'h2004, 16'h1234);
        d_wr = 1'b0;
        check_idle("after held");

        // Reset in cycle 6 of a fill aborts it; late beats are ignored.
        i_miss = 1'b1;
        i_miss_addr = 16'h0500;
        run_fill("abort", 16'h0500, 1'b0, 5, 1'b0);
        rst = 1'b1;
        i_miss = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 7; k <= 14; k++) begin
            check_idle($sformatf("abort c%0d", k));
        end
        $display("abort-reset errors=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
